dmem_readout_streamer: RTL and testbench

- Downstream consumer of the data memory. It replaces the simulation-only file dump with a synthesizable readout path.
- On a start request it walks a contiguous word range of dmem through its 32-bit read port and streams each word out on a valid/ready interface, with last-word marking.
- While active it asserts busy so the core stalls all dmem writes.

---
 rtl/dmem_readout_streamer_pkg.sv | 20 ++
 rtl/dmem_readout_streamer_fifo.sv | 63 ++++++
 rtl/dmem_readout_streamer.sv | 161 ++++++++++++++++
 tb/tb_dmem_readout_streamer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_readout_streamer_pkg.sv
// Shared types and default geometry for the dmem readout streamer.
// Optional feature macro used by the top: READOUT_CHECKSUM_EN.
package dmem_readout_pkg;

   localparam int DMEM_S    = 32;
   localparam int DMEM_SIZE = 30015;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } state_t;

   typedef struct packed {
      logic [DMEM_S-1:0] data;
      logic              last;
   } fifo_entry_t;

endpackage

// File: rtl/dmem_readout_streamer_fifo.sv
// Small show-ahead synchronous FIFO; the head entry is visible while not empty
// and stays put until popped.
module readout_fifo
   import dmem_readout_pkg::*;
#(
   parameter int  DEPTH = 2,
   parameter type T     = fifo_entry_t
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  T                       push_data,
   input  logic                   pop,
   output T                       head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);

   T               mem_reg [DEPTH];
   logic [AW-1:0]  wr_ptr_reg;
   logic [AW-1:0]  rd_ptr_reg;
   logic [AW:0]    count_reg;
   logic           do_push;
   logic           do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A push into a full FIFO is fine when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign head    = mem_reg[rd_ptr_reg];
   assign count   = count_reg;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_reg[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/dmem_readout_streamer.sv
// Streams a contiguous dmem word range out over valid/ready with last marking.
// Define READOUT_CHECKSUM_EN to add a running sum of streamed words on csum.
module dmem_readout_streamer
   import dmem_readout_pkg::*;
#(
   parameter int S          = DMEM_S,
   parameter int SIZE       = DMEM_SIZE,
   parameter int FIFO_DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [S-1:0] base_addr,
   input  logic [S-1:0] word_count,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic         mem_re,
   output logic [S-1:0] mem_addr,
   input  logic [S-1:0] mem_rdata,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [S-1:0] out_data,
   output logic         out_last
`ifdef READOUT_CHECKSUM_EN
   ,
   output logic [S-1:0] csum
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [S-1:0] data;
      logic         last;
   } entry_t;

   state_t        state_reg;
   state_t        state_next;
   logic [S-1:0]  base_reg;
   logic [S-1:0]  count_reg;
   logic [S-1:0]  idx_reg;
   logic          inflight_reg;
   logic          inflight_last_reg;
   logic          err_reg;

   logic [S:0]    end_addr;
   logic          reject;
   logic          accept;
   logic          pop;
   logic          issue_last;
   logic [CW:0]   occupancy;
   entry_t        push_entry;
   entry_t        head;
   logic [CW-1:0] fifo_count;
   logic          fifo_full;
   logic          fifo_empty;

   assign end_addr   = {1'b0, base_addr} + {1'b0, word_count};
   assign reject     = (word_count == '0) || (end_addr > (S+1)'(SIZE));
   assign accept     = (state_reg == IDLE) && start && !reject;
   assign pop        = out_valid & out_ready;
   assign issue_last = (idx_reg == count_reg - S'(1));
   // A word popped this cycle frees its slot in time for the read issued now.
   assign occupancy  = (CW+1)'(fifo_count) + (CW+1)'(inflight_reg) - (CW+1)'(pop);

   always_comb begin
      state_next = state_reg;
      mem_re     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = reject ? FIN : RUN;
            end
         end
         RUN: begin
            if ((idx_reg < count_reg) && (occupancy < (CW+1)'(FIFO_DEPTH)) &&
                (!fifo_full || pop)) begin
               mem_re = 1'b1;
               if (issue_last) begin
                  state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (pop && head.last) begin
               state_next = FIN;
            end
         end
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg         <= IDLE;
         base_reg          <= '0;
         count_reg         <= '0;
         idx_reg           <= '0;
         inflight_reg      <= 1'b0;
         inflight_last_reg <= 1'b0;
         err_reg           <= 1'b0;
      end else begin
         state_reg         <= state_next;
         err_reg           <= (state_reg == IDLE) && start && reject && (word_count != '0);
         inflight_reg      <= mem_re;
         inflight_last_reg <= mem_re & issue_last;
         if (accept) begin
            base_reg  <= base_addr;
            count_reg <= word_count;
            idx_reg   <= '0;
         end else if (mem_re) begin
            idx_reg <= idx_reg + S'(1);
         end
      end
   end

   assign push_entry = '{data: mem_rdata, last: inflight_last_reg};

   readout_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (entry_t)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight_reg),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign busy      = (state_reg != IDLE);
   assign done      = (state_reg == FIN);
   assign err       = err_reg;
   assign mem_addr  = mem_re ? (base_reg + idx_reg) : '0;
   assign out_valid = !fifo_empty;
   assign out_data  = out_valid ? head.data : '0;
   assign out_last  = out_valid & head.last;

`ifdef READOUT_CHECKSUM_EN
   logic [S-1:0] csum_reg;

   // Cleared by any start taken in IDLE, including rejected requests.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum_reg <= '0;
      end else if ((state_reg == IDLE) && start) begin
         csum_reg <= '0;
      end else if (pop) begin
         csum_reg <= csum_reg + out_data;
      end
   end

   assign csum = csum_reg;
`endif

endmodule

// File: tb/tb_dmem_readout_streamer.sv
// Directed bench for dmem_readout_streamer; memory model returns mem[i] = i*3.
module tb_dmem_readout_streamer;

   localparam int S    = 32;
   localparam int SIZE = 30015;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [S-1:0] base_addr = '0;
   logic [S-1:0] word_count = '0;
   logic         busy, done, err, mem_re;
   logic [S-1:0] mem_addr;
   logic [S-1:0] mem_rdata = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [S-1:0] out_data;
   logic         out_last;
`ifdef READOUT_CHECKSUM_EN
   logic [S-1:0] csum;
`endif

   int checks = 0;
   int errors = 0;
   bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   dmem_readout_streamer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .mem_re     (mem_re),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last)
`ifdef READOUT_CHECKSUM_EN
      ,
      .csum       (csum)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_re) mem_rdata <= mem_addr * 3;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one request and follows it to done, checking every handshake.
   task automatic run_check(input string tag, input logic [S-1:0] b, input logic [S-1:0] n,
                            input bit exp_err, input bit bp, input int inject_at);
      int k = 0;
      int issued = 0;
      int popped = 0;
      int done_c = -1;
      int nw;
      bit done_seen = 0;
      bit prev_stall = 0;
      logic [S-1:0] prev_data = '0;
      logic [S-1:0] exp_d;
      logic [S-1:0] sum = '0;
      nw = (exp_err || n == 0) ? 0 : int'(n);
      base_addr = b; word_count = n; start = 1'b1;
      step();
      start = 1'b0;
      chk({tag, "_busy_on_start"}, busy, 1);
`ifdef READOUT_CHECKSUM_EN
      chk({tag, "_csum_cleared"}, csum, 0);
`endif
      for (int c = 0; c < 200; c++) begin
         out_ready = bp ? pat[c % 4] : 1'b1;
         start = (c == inject_at);
         if (c == inject_at) begin
            base_addr = 500; word_count = 3;
         end
         #1;
         if (mem_re) issued++;
         if (prev_stall) begin
            chk({tag, "_stall_valid"}, out_valid, 1);
            chk({tag, "_stall_data"}, out_data, prev_data);
         end
         if (out_valid && out_ready) begin
            exp_d = (b + S'(k)) * 3;
            chk({tag, "_data"}, out_data, exp_d);
            chk({tag, "_last"}, out_last, (k == nw - 1));
            sum = sum + exp_d;
            k++;
            popped++;
         end
         chk({tag, "_outstanding_le2"}, (issued - popped <= 2), 1);
         prev_stall = out_valid && !out_ready;
         prev_data = out_data;
         if (done) begin
            done_seen = 1;
            done_c = c;
            break;
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      chk({tag, "_done_seen"}, done_seen, 1);
      chk({tag, "_err"}, err, exp_err);
      chk({tag, "_busy_at_done"}, busy, 1);
      chk({tag, "_words"}, k, nw);
      chk({tag, "_reads"}, issued, nw);
      if (nw == 0) chk({tag, "_done_cycle"}, done_c, 0);
`ifdef READOUT_CHECKSUM_EN
      chk({tag, "_csum"}, csum, sum);
`endif
      $display("txn %s base=%0d count=%0d words=%0d err=%0b", tag, b, n, k, err);
      step();
      chk({tag, "_idle_busy"}, busy, 0);
      chk({tag, "_idle_done"}, done, 0);
   endtask

   initial begin
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_mem_re", mem_re, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Basic stream with exact cycle timing.
      out_ready = 1'b1;
      base_addr = 100; word_count = 5; start = 1'b1;
      step();
      start = 1'b0;
      chk("basic_busy", busy, 1);
      chk("basic_re0", mem_re, 1);
      chk("basic_addr0", mem_addr, 100);
      chk("basic_nv1", out_valid, 0);
      step();
      chk("basic_nv2", out_valid, 0);
      chk("basic_addr1", mem_addr, 101);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("basic_valid", out_valid, 1);
         chk("basic_data", out_data, 300 + 3 * k);
         chk("basic_last", out_last, (k == 4));
         chk("basic_nodone", done, 0);
         $display("txn basic word=%0d data=%0d last=%0b", k, out_data, out_last);
      end
      step();
      chk("basic_done", done, 1);
      chk("basic_err", err, 0);
      chk("basic_busy_fin", busy, 1);
      chk("basic_tail_valid", out_valid, 0);
`ifdef READOUT_CHECKSUM_EN
      chk("basic_csum", csum, 1530);
`endif
      step();
      chk("basic_done_pulse", done, 0);
      chk("basic_idle", busy, 0);
      repeat (3) step();
`ifdef READOUT_CHECKSUM_EN
      chk("basic_csum_hold", csum, 1530);
`endif

      run_check("backpressure", 100, 5, 1'b0, 1'b1, -1);
      run_check("last_addr", SIZE - 1, 1, 1'b0, 1'b0, -1);
      run_check("exact_fit", SIZE - 3, 3, 1'b0, 1'b1, -1);
      run_check("overrun", SIZE - 1, 2, 1'b1, 1'b0, -1);
      run_check("zero_len", 7, 0, 1'b0, 1'b0, -1);
      run_check("start_busy", 100, 5, 1'b0, 1'b0, 1);

      // Asynchronous reset between clock edges after two words.
      out_ready = 1'b1;
      base_addr = 200; word_count = 6; start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      chk("mid_pre_data", out_data, 606);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_busy", busy, 0);
      chk("mid_valid", out_valid, 0);
      chk("mid_re", mem_re, 0);
      chk("mid_addr", mem_addr, 0);
      chk("mid_data", out_data, 0);
      chk("mid_last", out_last, 0);
      chk("mid_done", done, 0);
      chk("mid_err", err, 0);
`ifdef READOUT_CHECKSUM_EN
      chk("mid_csum", csum, 0);
`endif
      $display("txn async_reset busy=%0b out_valid=%0b", busy, out_valid);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      run_check("after_reset", 200, 3, 1'b0, 1'b0, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
